uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver and successor to the fixed-rate 8N1 sampler. Adds runtime baud divisor, configurable data width, optional parity, 3-sample majority vote, false-start rejection, and framing/parity error reporting. Frames are buffered in a small show-ahead FIFO with overrun detection. Sits behind the Wishbone peripheral wrapper, which drives rd/clr and routes irq.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9, LSB first on the wire
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_DEPTH, 4, entries, power of two, ≥2
DIV_WIDTH, 16, width of the baud divisor input

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
div  in  DIV_WIDTH  clk ticks per bit; captured at start detection; values <4 treated as 4
rx  in  1  asynchronous serial line, idle high
rd  in  1  pop strobe; removes head entry when valid=1
clr  in  1  clears overrun flag
data  out  DATA_BITS  head entry payload (show-ahead)
frame_err  out  1  head entry: stop bit sampled 0
parity_err  out  1  head entry: parity mismatch (always 0 when PARITY=0)
valid  out  1  FIFO non-empty
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overrun  out  1  sticky: a frame was dropped on a full FIFO
irq  out  1  equals valid

Behaviour:
- Reset (synchronous, active-high, also mid-frame): FSM → IDLE, bit/tick counters 0, FIFO emptied (level=0, valid=0), overrun=0, data/frame_err/parity_err=0, both synchroniser flops=1. A partially received frame is discarded.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: rs=0 → START, tick counter cnt=0, D=max(div,4) latched for the whole frame.
- Each bit period: cnt increments each clk from 0 to D-1, then wraps to 0 and advances the bit. Samples are taken at cnt = D/2-1, D/2, D/2+1 (integer division); bit value = majority of the three.
- START: a majority value of 1 is a false start → IDLE (no FIFO activity). Otherwise at cnt=D-1 → DATA with bit index 0.
- DATA: voted bit shifts in LSB first; after bit DATA_BITS-1 → PARITY if PARITY≠0, else STOP.
- PARITY: parity_err_n = (XOR of data bits XOR voted parity bit) != (PARITY==1).
- STOP: at cnt=D/2+1 (last vote sample), push {data, frame_err = !stop_vote, parity_err_n} and → IDLE at once; the rest of the stop bit is not waited out, so resync is immediate.
- Break condition (all-zero data, stop=0) is pushed as data=0 with frame_err=1. Error frames are always pushed.
- Push timing: valid rises and data reflects the frame on the clk after the final stop sample.
- FIFO: show-ahead, so data/frame_err/parity_err show the head combinationally from storage. rd with valid=0 is ignored.
- Push on full with no rd: frame dropped, overrun ← 1, contents unchanged.
- Push on full with rd in the same cycle: pop and push both happen, no overrun, level unchanged.
- Push and rd on non-empty, non-full: level unchanged.
- clr clears overrun. If clr and a new overrun event occur in the same cycle, overrun=1 (set wins).
- Pointers wrap modulo FIFO_DEPTH. level is in 0..FIFO_DEPTH.
- div changes mid-frame have no effect until the next start.

Test Plan:
- div=16, DATA_BITS=8, PARITY=2: send 0xA5 with parity bit 0 and stop 1 → valid=1, level=1, data=0xA5, frame_err=0, parity_err=0; rd pops → valid=0.
- Same configuration, send 0x01 with parity bit 0 → data=0x01, parity_err=1.
- PARITY=0: send 0x3C with stop bit held 0, then line high → data=0x3C, frame_err=1. Also send a break (0x00, stop 0) → data=0x00, frame_err=1.
- div=16: rx low pulse of 3 clk, then high → FSM returns to IDLE, level stays 0. Single-clk glitch inside a data bit → majority rejects it, received byte unchanged.
- FIFO_DEPTH=4: send 0x01..0x05 with no rd → level=4, overrun=1, pops give 0x01..0x04. clr → overrun=0. Fill again and assert rd in the cycle a 5th frame pushes → overrun stays 0, level=4.
- Assert rst mid-byte, release, then send 0x5A → only 0x5A received, level=1. Repeat with div=4 and div=2 (clamped to 4) → 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime baud divisor, 3-sample majority vote, optional parity,
// and a show-ahead receive FIFO with sticky overrun reporting.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIV_WIDTH-1:0]            div,
  input  logic                            rx,
  input  logic                            rd,
  input  logic                            clr,
  output logic [DATA_BITS-1:0]            data,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            valid,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            overrun,
  output logic                            irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned EW = DATA_BITS + 2;
  localparam logic [DIV_WIDTH-1:0] One    = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DivMin = DIV_WIDTH'(4);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rs_q;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d, dlen_q, dlen_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic                   perr_q, perr_d;
  logic                   push, vote;
  logic                   samp0, samp1, samp2, last;
  logic [DIV_WIDTH-1:0]   half;
  logic [EW-1:0]          push_entry;

  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overrun_q, overrun_d;
  logic                   pop, full, push_en;
  logic [EW-1:0]          head;

  assign half  = dlen_q >> 1;
  assign samp0 = (cnt_q == half - One);
  assign samp1 = (cnt_q == half);
  assign samp2 = (cnt_q == half + One);
  assign last  = (cnt_q == dlen_q - One);
  // Third sample is the live line value; the first two were captured earlier.
  assign vote  = (s0_q & s1_q) | (s0_q & rs_q) | (s1_q & rs_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = last ? '0 : cnt_q + One;
    dlen_d     = dlen_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    s0_d       = samp0 ? rs_q : s0_q;
    s1_d       = samp1 ? rs_q : s1_q;
    push       = 1'b0;
    push_entry = {perr_q, ~vote, shreg_q};
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        if (!rs_q) begin
          state_d = StStart;
          dlen_d  = (div < DivMin) ? DivMin : div;
        end
      end
      StStart: begin
        if (samp2 && vote) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (last) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (samp2) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
        if (last) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? StParity : StStop;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      StParity: begin
        if (samp2) perr_d = ((^shreg_q) ^ vote) != (PARITY == 1);
        if (last) state_d = StStop;
      end
      StStop: begin
        // Push on the last vote sample and resync without waiting out the stop bit.
        if (samp2) begin
          push    = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop     = rd && valid;
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign push_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d  = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q;
    if (push_en && !pop) level_d = level_q + LW'(1);
    if (!push_en && pop) level_d = level_q - LW'(1);
    overrun_d = overrun_q;
    if (push && full && !pop) overrun_d = 1'b1;
    else if (clr)             overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      dlen_q    <= DivMin;
      bit_q     <= '0;
      shreg_q   <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      perr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dlen_q    <= dlen_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      perr_q    <= perr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset: the head is gated by valid.
  always_ff @(posedge clk) begin
    if (!rst && push_en) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign valid      = (level_q != '0);
  assign irq        = valid;
  assign level      = level_q;
  assign overrun    = overrun_q;
  assign data       = valid ? head[DATA_BITS-1:0] : '0;
  assign frame_err  = valid & head[DATA_BITS];
  assign parity_err = valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: one even-parity receiver and one no-parity receiver driven side by side.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        rx_p, rd_p, clr_p, rx_n, rd_n, clr_n;
  logic [7:0]  data_p, data_n;
  logic        ferr_p, perr_p, valid_p, ovr_p, irq_p;
  logic        ferr_n, perr_n, valid_n, ovr_n, irq_n;
  logic [2:0]  level_p, level_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_par (
    .clk(clk), .rst(rst), .div(div), .rx(rx_p), .rd(rd_p), .clr(clr_p),
    .data(data_p), .frame_err(ferr_p), .parity_err(perr_p), .valid(valid_p),
    .level(level_p), .overrun(ovr_p), .irq(irq_p)
  );

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_np (
    .clk(clk), .rst(rst), .div(div), .rx(rx_n), .rd(rd_n), .clr(clr_n),
    .data(data_n), .frame_err(ferr_n), .parity_err(perr_n), .valid(valid_n),
    .level(level_n), .overrun(ovr_n), .irq(irq_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int port, input logic v);
    if (port == 0) rx_p = v;
    else           rx_n = v;
  endtask

  // Called just after a rising edge; glitch >= 0 flips the middle sample of that frame bit.
  task automatic send(input int port, input logic [7:0] d, input bit has_par, input bit par,
                      input bit stop, input int dd, input int glitch);
    logic [10:0] bits;
    int          n;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (has_par) begin
      bits[9]  = par;
      bits[10] = stop;
      n        = 11;
    end else begin
      bits[9] = stop;
      n       = 10;
    end
    for (int i = 0; i < n; i++) begin
      set_rx(port, bits[i]);
      if (i == glitch) begin
        repeat (9) @(posedge clk);
        #1 set_rx(port, ~bits[i]);
        @(posedge clk);
        #1 set_rx(port, bits[i]);
        repeat (dd - 10) @(posedge clk);
        #1;
      end else begin
        repeat (dd) @(posedge clk);
        #1;
      end
    end
    set_rx(port, 1'b1);
    repeat (3 * dd) @(posedge clk);
    #1;
  endtask

  task automatic pop(input int port);
    if (port == 0) rd_p = 1'b1;
    else           rd_n = 1'b1;
    @(posedge clk);
    #1;
    rd_p = 1'b0;
    rd_n = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    int de;
    int divs [3];
    divs = '{16, 4, 2};
    rst = 1'b1; div = 16'd16;
    rx_p = 1'b1; rx_n = 1'b1; rd_p = 1'b0; rd_n = 1'b0; clr_p = 1'b0; clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_p), 0);
    check("rst_level", 32'(level_p), 0);
    check("rst_data", 32'(data_p), 0);
    check("rst_ovr", 32'(ovr_n), 0);
    check("rst_irq", 32'(irq_n), 0);

    // Even parity: 0xA5 has four ones, parity bit 0 is correct
    send(0, 8'hA5, 1, 1'b0, 1'b1, 16, -1);
    check("a5_valid", 32'(valid_p), 1);
    check("a5_irq", 32'(irq_p), 1);
    check("a5_level", 32'(level_p), 1);
    check("a5_data", 32'(data_p), 'hA5);
    check("a5_ferr", 32'(ferr_p), 0);
    check("a5_perr", 32'(perr_p), 0);
    pop(0);
    check("a5_popped", 32'(valid_p), 0);

    send(0, 8'h01, 1, 1'b0, 1'b1, 16, -1);
    check("01_data", 32'(data_p), 'h01);
    check("01_perr", 32'(perr_p), 1);
    check("01_ferr", 32'(ferr_p), 0);
    pop(0);

    // Framing errors and break on the no-parity receiver
    send(1, 8'h3C, 0, 1'b0, 1'b0, 16, -1);
    check("3c_data", 32'(data_n), 'h3C);
    check("3c_ferr", 32'(ferr_n), 1);
    check("3c_perr", 32'(perr_n), 0);
    check("3c_level", 32'(level_n), 1);
    pop(1);
    send(1, 8'h00, 0, 1'b0, 1'b0, 16, -1);
    check("brk_data", 32'(data_n), 0);
    check("brk_ferr", 32'(ferr_n), 1);
    pop(1);
    check("brk_level", 32'(level_n), 0);

    // False start, then a glitched data bit
    set_rx(1, 1'b0);
    repeat (3) @(posedge clk);
    #1 set_rx(1, 1'b1);
    repeat (48) @(posedge clk);
    #1;
    check("fs_level", 32'(level_n), 0);
    check("fs_valid", 32'(valid_n), 0);
    send(1, 8'h96, 0, 1'b0, 1'b1, 16, 3);
    check("gl1_data", 32'(data_n), 'h96);
    check("gl1_ferr", 32'(ferr_n), 0);
    pop(1);
    send(1, 8'h96, 0, 1'b0, 1'b1, 16, 4);
    check("gl0_data", 32'(data_n), 'h96);
    pop(1);

    // Overrun on a full FIFO
    for (int i = 1; i <= 5; i++) send(1, 8'(i), 0, 1'b0, 1'b1, 16, -1);
    check("ovr_level", 32'(level_n), 4);
    check("ovr_flag", 32'(ovr_n), 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_pop", 32'(data_n), 32'(i));
      pop(1);
    end
    check("ovr_empty", 32'(valid_n), 0);
    check("ovr_sticky", 32'(ovr_n), 1);
    clr_n = 1'b1;
    @(posedge clk);
    #1 clr_n = 1'b0;
    check("clr_ovr", 32'(ovr_n), 0);

    // Refill, then pop in the very cycle the fifth frame is pushed
    for (int i = 1; i <= 4; i++) send(1, 8'(8'h10 + i), 0, 1'b0, 1'b1, 16, -1);
    check("refill_level", 32'(level_n), 4);
    fork
      send(1, 8'h15, 0, 1'b0, 1'b1, 16, -1);
      begin
        // start detect takes 3 edges; stop bit is bit 9; last vote at cnt = D/2+1
        repeat (3 + 9 * 16 + 8 + 1) @(posedge clk);
        #1 rd_n = 1'b1;
        @(posedge clk);
        #1 rd_n = 1'b0;
      end
    join
    check("sim_level", 32'(level_n), 4);
    check("sim_ovr", 32'(ovr_n), 0);
    for (int i = 2; i <= 5; i++) begin
      check("sim_pop", 32'(data_n), 32'(8'h10 + i));
      pop(1);
    end

    // Reset mid-frame, then a clean frame, across several divisors
    for (int k = 0; k < 3; k++) begin
      div = 16'(divs[k]);
      de  = (divs[k] < 4) ? 4 : divs[k];
      set_rx(1, 1'b0);
      repeat (de * 3) @(posedge clk);
      #1 rst = 1'b1;
      set_rx(1, 1'b1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("mrst_level", 32'(level_n), 0);
      send(1, 8'h5A, 0, 1'b0, 1'b1, de, -1);
      check("mrst_cnt", 32'(level_n), 1);
      check("mrst_data", 32'(data_n), 'h5A);
      check("mrst_ferr", 32'(ferr_n), 0);
      pop(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
